// File: rtl/write_frame_ctrl.sv
// write_frame_ctrl: ingress stage in front of the line-buffer write pointer.
// Registers the byte-wide receive stream, writes accepted bytes into buffer
// RAM, and ends each frame with either a commit (wr_newline plus a push of
// the frame length) or a rewind (wr_restart_line). Frame start is refused
// while all four lines are occupied.
// Optional build macro WRITE_FRAME_CTRL_SFD_STRIP_EN: strips the preamble
// and the 0xD5 start-of-frame delimiter before any byte is written.
module write_frame_ctrl #(
  parameter int MAX_FRAME_LEN = 2047,
  parameter int MIN_FRAME_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rx_data,
  input  logic [2:0]  wr_ptr_tribit,
  input  logic [2:0]  rd_ptr_tribit,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic        wr_char_incr,
  output logic        wr_newline,
  output logic        wr_restart_line,
  output logic        len_wr_en,
  output logic [10:0] len_data,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_drop_cnt
);

  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
`ifdef WRITE_FRAME_CTRL_SFD_STRIP_EN
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  // All four lines hold uncommitted-to-reader data: same line, opposite wrap.
  function automatic logic line_full(input logic [2:0] wr_tri,
                                     input logic [2:0] rd_tri);
    return (wr_tri[1:0] == rd_tri[1:0]) && (wr_tri[2] != rd_tri[2]);
  endfunction

  // Free-running 16-bit event counter step; wraps 0xFFFF -> 0.
  function automatic logic [15:0] wrap_inc(input logic [15:0] val,
                                           input logic        en);
    return val + {15'd0, en};
  endfunction

  logic        rx_dv_p0;
  logic        rx_er_p0;
  logic [7:0]  rx_data_p0;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] count;
  logic [10:0] count_nxt;
  logic        post_rst;

  logic        write_nxt;
  logic        newline_nxt;
  logic        restart_nxt;
  logic        ok_inc;
  logic        drop_inc;

  // Stage p0: input register; free-running so the first post-reset cycle
  // already sees the true line state.
  always_ff @(posedge clk) begin
    rx_dv_p0   <= rx_dv;
    rx_er_p0   <= rx_er;
    rx_data_p0 <= rx_data;
  end

  // Next-state and next-output decisions from the registered receive stream.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    write_nxt   = 1'b0;
    newline_nxt = 1'b0;
    restart_nxt = 1'b0;
    ok_inc      = 1'b0;
    drop_inc    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_dv_p0) begin
          if (post_rst) begin
            // Joined mid-frame straight out of reset: ignore it silently.
            state_nxt = S_DROP;
          end else if (line_full(wr_ptr_tribit, rd_ptr_tribit)) begin
            state_nxt = S_DROP;
            drop_inc  = 1'b1;
          end else if (rx_er_p0) begin
            // Nothing written yet, so no pointer command is needed.
            state_nxt = S_DROP;
            drop_inc  = 1'b1;
          end else begin
`ifdef WRITE_FRAME_CTRL_SFD_STRIP_EN
            count_nxt = '0;
            state_nxt = (rx_data_p0 == SFD_BYTE) ? S_DATA : S_PREAMBLE;
`else
            write_nxt = 1'b1;
            count_nxt = 11'd1;
            state_nxt = S_DATA;
`endif
          end
        end
      end
      S_PREAMBLE: begin
`ifdef WRITE_FRAME_CTRL_SFD_STRIP_EN
        if (!rx_dv_p0) begin
          state_nxt = S_IDLE;
          drop_inc  = 1'b1;
        end else if (rx_er_p0) begin
          state_nxt = S_DROP;
          drop_inc  = 1'b1;
        end else if (rx_data_p0 == SFD_BYTE) begin
          state_nxt = S_DATA;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      S_DATA: begin
        if (rx_dv_p0) begin
          if (rx_er_p0 || (count == MAX_LEN)) begin
            restart_nxt = 1'b1;
            drop_inc    = 1'b1;
            state_nxt   = S_DROP;
          end else begin
            write_nxt = 1'b1;
            count_nxt = count + 11'd1;
          end
        end else begin
          if (count < MIN_LEN) begin
            restart_nxt = 1'b1;
            drop_inc    = 1'b1;
          end else begin
            newline_nxt = 1'b1;
            ok_inc      = 1'b1;
          end
          state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (!rx_dv_p0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: state register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      count           <= '0;
      post_rst        <= 1'b1;
      wr_en           <= 1'b0;
      wr_data         <= '0;
      wr_char_incr    <= 1'b0;
      wr_newline      <= 1'b0;
      wr_restart_line <= 1'b0;
      len_wr_en       <= 1'b0;
      len_data        <= '0;
      frame_ok_cnt    <= '0;
      frame_drop_cnt  <= '0;
    end else begin
      state           <= state_nxt;
      count           <= count_nxt;
      post_rst        <= 1'b0;
      wr_en           <= write_nxt;
      wr_char_incr    <= write_nxt;
      if (write_nxt) wr_data <= rx_data_p0;
      wr_newline      <= newline_nxt;
      wr_restart_line <= restart_nxt;
      len_wr_en       <= newline_nxt;
      if (newline_nxt) len_data <= count;
      frame_ok_cnt    <= wrap_inc(frame_ok_cnt, ok_inc);
      frame_drop_cnt  <= wrap_inc(frame_drop_cnt, drop_inc);
    end
  end

endmodule

// File: tb/tb_write_frame_ctrl.sv
// Testbench for write_frame_ctrl: frame-level reference model feeding
// expectation queues, with an independent monitor popping and comparing
// every RAM write and every commit/rewind the DUT issues.
module tb_write_frame_ctrl;

  localparam int MAX_LEN = 2047;
  localparam int MIN_LEN = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rx_data;
  logic [2:0]  wr_tri;
  logic [2:0]  rd_tri;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_char_incr;
  logic        wr_newline;
  logic        wr_restart_line;
  logic        len_wr_en;
  logic [10:0] len_data;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_drop_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int model_ok   = 0;
  int model_drop = 0;
  bit mon_en = 1'b0;

  logic [7:0] exp_wr[$];
  int         exp_evt[$];   // -1 = rewind, otherwise committed length
  int         mon_e;

  write_frame_ctrl #(.MAX_FRAME_LEN(MAX_LEN), .MIN_FRAME_LEN(MIN_LEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_dv          (rx_dv),
    .rx_er          (rx_er),
    .rx_data        (rx_data),
    .wr_ptr_tribit  (wr_tri),
    .rd_ptr_tribit  (rd_tri),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_char_incr   (wr_char_incr),
    .wr_newline     (wr_newline),
    .wr_restart_line(wr_restart_line),
    .len_wr_en      (len_wr_en),
    .len_data       (len_data),
    .frame_ok_cnt   (frame_ok_cnt),
    .frame_drop_cnt (frame_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    n_total++;
    $display("FAIL %s: unexpected output 0x%0h with nothing expected", name, got);
  endtask

  // Monitor: compares every DUT output event against the expectation queues.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (wr_char_incr || wr_newline || wr_restart_line)
        check("cmd_onehot", 32'(wr_char_incr) + 32'(wr_newline) + 32'(wr_restart_line), 32'd1);
      if (wr_en || wr_char_incr) begin
        check("wr_en_vs_incr", 32'(wr_en), 32'(wr_char_incr));
        if (exp_wr.size() == 0) unexpected("wr_data", 32'(wr_data));
        else check("wr_data", 32'(wr_data), 32'(exp_wr.pop_front()));
      end
      if (wr_newline || wr_restart_line) begin
        if (exp_evt.size() == 0) begin
          unexpected("frame_end", {30'd0, wr_newline, wr_restart_line});
        end else begin
          mon_e = exp_evt.pop_front();
          check("end_is_commit", 32'(wr_newline), (mon_e >= 0) ? 32'd1 : 32'd0);
          check("len_wr_en", 32'(len_wr_en), 32'(wr_newline));
          if (wr_newline && mon_e >= 0) check("len_data", 32'(len_data), 32'(mon_e));
        end
      end else if (len_wr_en) begin
        unexpected("len_wr_en", 32'(len_data));
      end
    end
  end

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_dv   = dv;
    rx_er   = er;
    rx_data = d;
  endtask

  // Reference model at frame level, then the frame on the wire.
  task automatic send_frame(input int len, input int er_pos, input logic [2:0] wt,
                            input logic [2:0] rt, input int gap, input bit incr_pat);
    logic [7:0] pl[$];
    int  fail_idx;
    bit  full;
    for (int i = 0; i < len; i++) pl.push_back(incr_pat ? 8'(i) : 8'($urandom));
    full = (wt[1:0] == rt[1:0]) && (wt[2] != rt[2]);
    fail_idx = er_pos;
    if (len > MAX_LEN && (fail_idx == 0 || MAX_LEN + 1 < fail_idx)) fail_idx = MAX_LEN + 1;
    if (full) begin
      model_drop++;
    end else if (fail_idx != 0) begin
      for (int i = 0; i < fail_idx - 1; i++) exp_wr.push_back(pl[i]);
      exp_evt.push_back(-1);
      model_drop++;
    end else begin
      for (int i = 0; i < len; i++) exp_wr.push_back(pl[i]);
      if (len < MIN_LEN) begin
        exp_evt.push_back(-1);
        model_drop++;
      end else begin
        exp_evt.push_back(len);
        model_ok++;
      end
    end
    @(posedge clk);
    #1;
    wr_tri = wt;
    rd_tri = rt;
`ifdef WRITE_FRAME_CTRL_SFD_STRIP_EN
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
`endif
    for (int i = 0; i < len; i++) drive(1'b1, (i + 1 == er_pos), pl[i]);
    for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic settle(input string name);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 8'h00);
    check({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    check({name, "_evt_left"}, 32'(exp_evt.size()), 32'd0);
    check({name, "_ok_cnt"}, 32'(frame_ok_cnt), 32'(16'(model_ok)));
    check({name, "_drop_cnt"}, 32'(frame_drop_cnt), 32'(16'(model_drop)));
    exp_wr.delete();
    exp_evt.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wr_en"}, 32'(wr_en), 32'd0);
    check({name, "_wr_data"}, 32'(wr_data), 32'd0);
    check({name, "_incr"}, 32'(wr_char_incr), 32'd0);
    check({name, "_newline"}, 32'(wr_newline), 32'd0);
    check({name, "_restart"}, 32'(wr_restart_line), 32'd0);
    check({name, "_len_wr_en"}, 32'(len_wr_en), 32'd0);
    check({name, "_len_data"}, 32'(len_data), 32'd0);
    check({name, "_ok"}, 32'(frame_ok_cnt), 32'd0);
    check({name, "_drop"}, 32'(frame_drop_cnt), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, er_pos, gap;
    logic [2:0] wt, rt;
    rst = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    wr_tri = 3'b000; rd_tri = 3'b000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    send_frame(64, 0, 3'b000, 3'b000, 1, 1'b1);
    settle("frame64");
    send_frame(30, 0, 3'b000, 3'b000, 1, 1'b0);
    settle("runt30");
    send_frame(100, 50, 3'b000, 3'b000, 1, 1'b0);
    settle("err50");
    send_frame(64, 0, 3'b100, 3'b000, 1, 1'b0);
    settle("full");
    send_frame(64, 0, 3'b100, 3'b001, 1, 1'b0);
    settle("not_full");
    send_frame(2048, 0, 3'b000, 3'b000, 1, 1'b0);
    send_frame(60, 0, 3'b000, 3'b000, 1, 1'b0);
    settle("oversize");
    send_frame(2047, 0, 3'b010, 3'b010, 1, 1'b0);
    send_frame(59, 0, 3'b010, 3'b010, 1, 1'b0);
    send_frame(60, 0, 3'b010, 3'b010, 1, 1'b0);
    settle("bounds");
    send_frame(64, 0, 3'b001, 3'b000, 1, 1'b0);
    send_frame(70, 0, 3'b001, 3'b000, 1, 1'b0);
    send_frame(80, 0, 3'b001, 3'b000, 1, 1'b0);
    settle("b2b");

    for (int k = 0; k < 40; k++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(58, 61) : $urandom_range(1, 140);
      er_pos = 0;
      if ($urandom_range(0, 4) == 0 && len >= 2) er_pos = $urandom_range(2, len);
      wt = 3'($urandom);
      rt = 3'($urandom);
      gap = $urandom_range(1, 3);
      send_frame(len, er_pos, wt, rt, gap, 1'b0);
    end
    settle("random");

    // Reset in the middle of a frame: the frame must vanish without any command.
    mon_en = 1'b0;
    wr_tri = 3'b000; rd_tri = 3'b000;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i));
    rst = 1'b1;
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 8'(i));
    @(negedge clk);
    check_reset_outputs("midrst");
    #1;
    rst = 1'b0;
    exp_wr.delete();
    exp_evt.delete();
    model_ok = 0;
    model_drop = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i));
    settle("midrst_after");
    send_frame(64, 0, 3'b000, 3'b000, 1, 1'b1);
    settle("post_rst_frame");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
